lockout_timer: RTL and testbench
================================

# lockout_timer

Loadable BCD down-counter timer for the lock controller; it counts down when a wrong code locks the keypad out and pulses `expired` when the lockout ends. It is the decrementing counterpart of the existing modulo up-counter. The up-counter produces a carry on wrap; this block consumes a tick enable and produces a borrow chain down to zero. It sits between the 1 Hz prescaler (`tick`) and the lock FSM, which loads, starts and pauses it and drives the display from `count`.

## Interface
- `DIGITS`, 4: number of BCD digits in `count`.
- `TIME_FMT`, 1: digit modulus selection.
  - 1: odd-index digits are mod 6, giving an mm:ss layout.
  - 0: all digits are mod 10.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tick` input 1: count enable, one-cycle pulse from the prescaler.
- `load` input 1: load `load_val` and return to IDLE.
- `load_val` input 4*DIGITS: preset value; digit 0 is in bits [3:0].
- `start` input 1: begin or resume counting.
- `stop` input 1: pause counting.
- `count` output 4*DIGITS: current BCD value, registered.
- `running` output 1: high while in RUN.
- `zero` output 1: `count` equals all-zero.
- `expired` output 1: one-cycle pulse when the count reaches zero while running.

## Operation
- States: IDLE, RUN, PAUSE, DONE. The encoding is fixed in the package.
- Reset values:
  - state = IDLE, `count` = 0, `running` = 0, `expired` = 0.
  - `zero` = 1 (combinational from `count`).
- Command priority, evaluated each cycle: `load` > `stop` > `start` > `tick`.
- `load`, any state: `count` <= clamped `load_val`, next state IDLE.
  - Each digit above its maximum is clamped to the maximum: 9, or 5 for mod-6 digits.
- IDLE or PAUSE + `start`:
  - If `count` != 0: go to RUN.
  - If `count` == 0: stay in the current state; no `expired`.
- RUN + `stop`: go to PAUSE; `count` holds.
- RUN + `tick`: decrement with a borrow chain.
  - Digit i decrements when every lower digit is 0.
  - A digit at 0 that decrements wraps to its maximum (modulus−1).
- RUN + `tick` with `count` == 1 (only digit 0 nonzero, and it equals 1):
  - `count` becomes 0 and the next state is DONE.
  - `expired` is high for exactly that one following cycle.
- DONE: `start`, `stop` and `tick` are ignored. Only `load` leaves DONE.
- `tick` outside RUN is ignored.
- The counter never wraps past zero; all-zero is terminal.

## Timing
- All state and `count` changes take effect on the rising clk edge where the input is sampled high. Latency is one cycle.
- `tick` and `start` in the same cycle in IDLE:
  - The state moves to RUN.
  - No decrement in that cycle; the first decrement happens on the next `tick`.
- `tick` and `stop` in the same cycle in RUN: the state moves to PAUSE with no decrement.
- `tick` and `load` in the same cycle: the load wins and no decrement occurs.
- `expired` is registered and aligned with the first cycle in which `count` == 0 and the state is DONE.
- `running` is registered and mirrors state == RUN in the same cycle.
- `rst_n` low mid-count: all outputs go to their reset values immediately, without waiting for clk. Counting resumes only after a `load` and a `start`.

## Structure
- Package `lockout_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - the digit width constant, 4;
  - a function returning the digit modulus from digit index and `TIME_FMT`.
- Sub-module `bcd_down_digit`: one mod-N down digit.
  - Inputs: `clk`, `rst_n`, `load`, `load_digit`, `dec`.
  - Outputs: `digit`, `is_zero`, `borrow` (= `dec` & `is_zero`).
  - Clamping is done inside the digit.
- The top level instantiates DIGITS copies. The `dec` input of digit i+1 is the `borrow` of digit i, and the FSM drives `dec` of digit 0.

## Test plan
- Reset and basic load:
  - Assert `rst_n`=0 mid-RUN: `count`=0, `zero`=1, `running`=0 asynchronously.
  - Load 0x0130, then `start`: `running`=1 on the next cycle.
- mm:ss borrow, `TIME_FMT`=1:
  - Load 0x0100, start, apply one `tick`: `count`=0x0059.
  - Apply one more `tick`: `count`=0x0058.
- Expiry:
  - Load 0x0002, start, apply two `tick`s.
  - `count`=0x0000, state DONE, `expired` high for exactly one cycle, `running`=0.
  - Further `tick`s and `start`s leave `count` unchanged.
- Priority collisions:
  - In RUN, `tick` with `stop` at 0x0010: state PAUSE, `count` stays 0x0010.
  - `tick` with `load`=0x0005: `count`=0x0005, state IDLE.
- Clamping and zero start:
  - Load 0x9F7C with `TIME_FMT`=1: `count`=0x5959.
  - Load 0x0000, then `start`: remains IDLE, `expired`=0.
- Pause and resume:
  - Start at 0x0003, one `tick`, `stop`, three `tick`s: `count` stays 0x0002.
  - `start`, then two `tick`s: `count`=0x0000 and `expired` pulses once.

Source files
------------

// File: rtl/lockout_pkg.sv
// Shared types for the lockout timer: FSM state encoding, BCD digit width and digit modulus helper.
// Pure declarations; no logic or timing of its own.
package lockout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DIGIT_W = 4;

  // In mm:ss layout the tens-of-seconds and tens-of-minutes digits (odd indices) are mod 6.
  function automatic logic [3:0] digit_mod(input int idx, input bit time_fmt);
    return (time_fmt && idx[0]) ? 4'd6 : 4'd10;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One mod-MOD BCD down digit with clamped load; updates one cycle after load/dec.
// No backpressure: load and dec are acted on in the cycle they are sampled.
module bcd_down_digit
  import lockout_pkg::*;
#(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               dec,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_zero,
  output logic               borrow
);

  localparam logic [3:0] MAX = MOD - 4'd1;

  logic [DIGIT_W-1:0] digit_q, digit_d;

  assign digit   = digit_q;
  assign is_zero = (digit_q == '0);
  assign borrow  = dec & is_zero;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = (load_digit > MAX) ? MAX : load_digit;
    end else if (dec) begin
      digit_d = is_zero ? MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/lockout_timer.sv
// Loadable BCD down-counter with IDLE/RUN/PAUSE/DONE control; commands take effect one cycle later.
// No backpressure: commands are prioritised load > stop > start > tick and never stall.
module lockout_timer
  import lockout_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit TIME_FMT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      start,
  input  logic                      stop,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      running,
  output logic                      zero,
  output logic                      expired
);

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   expired_q, expired_d;
  logic   dec0;
  logic   underflow;
  logic   upper_zero;
  logic   count_is_one;
  logic [DIGITS-1:0] dig_zero;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic dec_w;
    logic borrow_w;

    if (i == 0) begin : g_lsd
      assign dec_w = dec0;
    end else begin : g_chain
      assign dec_w = g_dig[i-1].borrow_w;
    end

    bcd_down_digit #(
      .MOD(digit_mod(i, TIME_FMT))
    ) u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_digit(load_val[DIGIT_W*i +: DIGIT_W]),
      .dec       (dec_w),
      .digit     (count[DIGIT_W*i +: DIGIT_W]),
      .is_zero   (dig_zero[i]),
      .borrow    (borrow_w)
    );
  end

  // A borrow out of the top digit would mean wrapping past zero; treat it as terminal.
  assign underflow = g_dig[DIGITS-1].borrow_w;
  assign zero      = &dig_zero;
  assign running   = running_q;
  assign expired   = expired_q;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      upper_zero = upper_zero & dig_zero[i];
    end
    count_is_one = upper_zero && (count[DIGIT_W-1:0] == 4'd1);
  end

  always_comb begin
    state_d   = state_q;
    dec0      = 1'b0;
    expired_d = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (start) begin
      if ((state_q == ST_IDLE || state_q == ST_PAUSE) && !zero) begin
        state_d = ST_RUN;
      end
    end else if (tick && state_q == ST_RUN) begin
      dec0 = !zero;
      if (count_is_one || underflow) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: tb/tb_lockout_timer.sv
// Directed bench for lockout_timer (4 digits, mm:ss): stimulus pushes hand-computed expectations,
// a separate monitor pops and compares them against the DUT outputs.
module tb_lockout_timer;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        tick     = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic        start    = 1'b0;
  logic        stop     = 1'b0;
  logic [15:0] count;
  logic        running;
  logic        zero;
  logic        expired;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        run;
    logic        zr;
    logic        ex;
  } exp_t;

  exp_t sb_q[$];

  lockout_timer #(.DIGITS(4), .TIME_FMT(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .stop    (stop),
    .count   (count),
    .running (running),
    .zero    (zero),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string name, input logic [15:0] cnt, input logic run,
                            input logic ex);
    exp_t e;
    e.name = name;
    e.cnt  = cnt;
    e.run  = run;
    e.zr   = (cnt == 16'h0);
    e.ex   = ex;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string fld, input logic [15:0] act,
                     input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %h, expected %h", name, fld, act, req);
    end
  endtask

  // Drive one cycle of commands at the falling edge, return just after the rising edge.
  task automatic cyc(input logic ld, input logic [15:0] lv, input logic st, input logic sp,
                     input logic tk);
    @(negedge clk);
    load     = ld;
    load_val = lv;
    start    = st;
    stop     = sp;
    tick     = tk;
    @(posedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are sampled 1 time unit after each expectation is posted.
  initial begin
    exp_t e;
    forever begin
      wait (sb_q.size() != 0);
      #1;
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "count",   count,           e.cnt);
        cmp(e.name, "running", {15'h0, running}, {15'h0, e.run});
        cmp(e.name, "zero",    {15'h0, zero},    {15'h0, e.zr});
        cmp(e.name, "expired", {15'h0, expired}, {15'h0, e.ex});
      end
    end
  end

  initial begin
    #2;
    expect_out("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load/start, then asynchronous reset mid-count
    cyc(1, 16'h0130, 0, 0, 0); expect_out("load_0130",  16'h0130, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("start_0130", 16'h0130, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0130",  16'h0129, 1, 0);
    @(negedge clk);
    {load, start, stop, tick} = 4'b0;
    #2 rst_n = 1'b0;
    expect_out("async_rst", 16'h0000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 16'h0,    1, 0, 0); expect_out("post_rst_start", 16'h0000, 0, 0);

    // mm:ss borrow chain
    cyc(1, 16'h0100, 0, 0, 0); expect_out("load_0100",  16'h0100, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("start_0100", 16'h0100, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0059",  16'h0059, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0058",  16'h0058, 1, 0);
    cyc(1, 16'h1000, 0, 0, 0); expect_out("load_1000",  16'h1000, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("start_1000", 16'h1000, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0959",  16'h0959, 1, 0);

    // Expiry and DONE stickiness
    cyc(1, 16'h0002, 0, 0, 0); expect_out("load_0002",  16'h0002, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("start_0002", 16'h0002, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0001",  16'h0001, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("expire",     16'h0000, 0, 1);
    idle();                    expect_out("expire_end", 16'h0000, 0, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("done_tick",  16'h0000, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("done_start", 16'h0000, 0, 0);
    cyc(0, 16'h0,    1, 0, 1); expect_out("done_st_tk", 16'h0000, 0, 0);

    // Priority collisions
    cyc(1, 16'h0010, 0, 0, 0); expect_out("load_0010",  16'h0010, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("start_0010", 16'h0010, 1, 0);
    cyc(0, 16'h0,    0, 1, 1); expect_out("stop_tick",  16'h0010, 0, 0);
    cyc(1, 16'h0005, 0, 0, 1); expect_out("load_tick",  16'h0005, 0, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("idle_tick",  16'h0005, 0, 0);
    cyc(0, 16'h0,    1, 0, 1); expect_out("start_tick", 16'h0005, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0004",  16'h0004, 1, 0);

    // Clamping and zero start
    cyc(1, 16'h9F7C, 0, 0, 0); expect_out("clamp",      16'h5959, 0, 0);
    cyc(1, 16'h0000, 0, 0, 0); expect_out("load_zero",  16'h0000, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("zero_start", 16'h0000, 0, 0);

    // Pause and resume
    cyc(1, 16'h0003, 0, 0, 0); expect_out("load_0003",  16'h0003, 0, 0);
    cyc(0, 16'h0,    1, 0, 0); expect_out("start_0003", 16'h0003, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("tick_0002",  16'h0002, 1, 0);
    cyc(0, 16'h0,    0, 1, 0); expect_out("pause",      16'h0002, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 16'h0, 0, 0, 1); expect_out("pause_tick", 16'h0002, 0, 0);
    end
    cyc(0, 16'h0,    1, 0, 0); expect_out("resume",     16'h0002, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("res_0001",   16'h0001, 1, 0);
    cyc(0, 16'h0,    0, 0, 1); expect_out("res_expire", 16'h0000, 0, 1);
    idle();                    expect_out("res_end",    16'h0000, 0, 0);

    idle();
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
